// File: rtl/digital_set_ctrl.sv
// Button-driven set-mode controller: turns mode/increment buttons into one-cycle field set pulses.
// Optional macro DIGITAL_SET_FREEZE_EN holds the clock block (run_en low) while a field is being set.
module digital_set_ctrl #(
    parameter int REPEAT_DLY  = 3,
    parameter int REPEAT_RATE = 1,
    parameter int TIMEOUT     = 30,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       res,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sc,
    output logic       mn,
    output logic       hrs,
    output logic       dt,
    output logic       mon,
    output logic       yr,
    output logic [2:0] field,
    output logic       set_active,
    output logic       blink,
    output logic       run_en
);

    typedef enum logic [2:0] {
        RUN = 3'd0,
        SEC = 3'd1,
        MIN = 3'd2,
        HR  = 3'd3,
        DD  = 3'd4,
        MM  = 3'd5,
        YY  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DLY_C  = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] RATE_C = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT - 1);

    state_t           state, stateNext;
    logic             modePrev, incPrev;
    logic [CNT_W-1:0] repCnt, repCntNext;
    logic             repRunning, repRunningNext;
    logic [CNT_W-1:0] idleCnt, idleCntNext;
    logic [5:0]       pulses, pulsesNext;
    logic             blinkReg, blinkNext;
    logic             fire;
    logic             modeRise, incRise;

    assign modeRise = btn_mode & ~modePrev;
    assign incRise  = btn_inc & ~incPrev;

    // repCnt == 0 means no repeat armed; it only becomes nonzero on an inc rise inside a set state.
    always_comb begin
        stateNext      = state;
        repCntNext     = repCnt;
        repRunningNext = repRunning;
        idleCntNext    = idleCnt;
        pulsesNext     = '0;
        fire           = 1'b0;
        if (state == RUN) begin
            repCntNext     = '0;
            repRunningNext = 1'b0;
            idleCntNext    = '0;
            if (modeRise)
                stateNext = SEC;
        end else if (modeRise) begin
            stateNext      = (state == YY) ? RUN : state_t'(state + 3'd1);
            repCntNext     = '0;
            repRunningNext = 1'b0;
            idleCntNext    = '0;
        end else if (btn_inc) begin
            idleCntNext = '0;
            if (incRise) begin
                fire           = 1'b1;
                repCntNext     = CNT_W'(1);
                repRunningNext = 1'b0;
            end else if (repCnt != '0) begin
                if (repCnt == (repRunning ? RATE_C : DLY_C)) begin
                    fire           = 1'b1;
                    repCntNext     = CNT_W'(1);
                    repRunningNext = 1'b1;
                end else begin
                    repCntNext = repCnt + CNT_W'(1);
                end
            end
        end else begin
            repCntNext     = '0;
            repRunningNext = 1'b0;
            if (idleCnt == TO_C) begin
                stateNext   = RUN;
                idleCntNext = '0;
            end else begin
                idleCntNext = idleCnt + CNT_W'(1);
            end
        end

        if (fire) begin
            case (state)
                SEC:     pulsesNext = 6'b000001;
                MIN:     pulsesNext = 6'b000010;
                HR:      pulsesNext = 6'b000100;
                DD:      pulsesNext = 6'b001000;
                MM:      pulsesNext = 6'b010000;
                YY:      pulsesNext = 6'b100000;
                default: pulsesNext = 6'b000000;
            endcase
        end
        blinkNext = (stateNext != RUN) ? ~blinkReg : 1'b0;
    end

    // Button history loads 1 in reset so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (res) begin
            state      <= RUN;
            modePrev   <= 1'b1;
            incPrev    <= 1'b1;
            repCnt     <= '0;
            repRunning <= 1'b0;
            idleCnt    <= '0;
            pulses     <= '0;
            blinkReg   <= 1'b0;
        end else begin
            state      <= stateNext;
            modePrev   <= btn_mode;
            incPrev    <= btn_inc;
            repCnt     <= repCntNext;
            repRunning <= repRunningNext;
            idleCnt    <= idleCntNext;
            pulses     <= pulsesNext;
            blinkReg   <= blinkNext;
        end
    end

    assign sc         = pulses[0];
    assign mn         = pulses[1];
    assign hrs        = pulses[2];
    assign dt         = pulses[3];
    assign mon        = pulses[4];
    assign yr         = pulses[5];
    assign field      = state;
    assign set_active = (state != RUN);
    assign blink      = blinkReg;

`ifdef DIGITAL_SET_FREEZE_EN
    assign run_en = ~set_active;
`else
    assign run_en = 1'b1;
`endif

endmodule
